// File: rtl/stream_mux_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_pkg
// Description : Shared constants, FSM state type and round-robin helper for
//               the stream_mux_rr packet multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_mux_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Search distance of channel idx, counted upward from slot ptr+1 (0 = first choice).
    function automatic int rr_distance(input int idx, input int ptr, input int n);
        int d;
        d = idx - ptr - 1;
        if (d < 0) begin
            d = d + n;
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_rr_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr_if
// Description : Producer/consumer handshake bundle of the packet multiplexer.
//               slave = multiplexer side, master = surrounding environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_mux_rr_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    localparam int SELW = $clog2(N_CH);

    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_last;
    logic [N_CH-1:0]       in_ready;
    logic [SELW-1:0]       sel;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;
    logic [SELW-1:0]       grant_idx;
    logic                  busy;

    modport slave (
        input  in_data, in_valid, in_last, sel, out_ready,
        output in_ready, out_data, out_valid, out_last, grant_idx, busy
    );

    modport master (
        output in_data, in_valid, in_last, sel, out_ready,
        input  in_ready, out_data, out_valid, out_last, grant_idx, busy
    );

endinterface
`default_nettype wire

// File: rtl/stream_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational N-way round-robin search starting at ptr+1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]         i_req,
    input  logic [$clog2(N_CH)-1:0] i_ptr,
    output logic                    o_found,
    output logic [$clog2(N_CH)-1:0] o_idx
);

    localparam int IDXW = $clog2(N_CH);

    int w_dist;
    int w_best;

    // Requester with the smallest wrapped distance from ptr+1 wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_best  = N_CH;
        w_dist  = 0;
        for (int i = 0; i < N_CH; i++) begin
            w_dist = rr_distance(i, int'(i_ptr), N_CH);
            if (i_req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_idx   = IDXW'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr
// Description : N-channel packet multiplexer with round-robin or fixed-select
//               arbitration, packet locking on last and a registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int MODE  = MODE_RR
) (
    input  logic            clk,
    input  logic            rst,
    stream_mux_rr_if.slave  bus
);

    localparam int SELW = $clog2(N_CH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SELW-1:0]   r_grant;
    logic [SELW-1:0]   r_ptr;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_valid;
    logic              r_out_last;

    logic              w_rr_found;
    logic [SELW-1:0]   w_rr_idx;
    logic              w_fix_found;
    logic [SELW-1:0]   w_fix_idx;
    logic              w_cand_found;
    logic [SELW-1:0]   w_cand_idx;

    logic [WIDTH-1:0]  w_grant_data;
    logic              w_grant_valid;
    logic              w_grant_last;
    logic              w_slot_free;
    logic              w_take;
    logic              w_take_last;
    logic [N_CH-1:0]   w_in_ready;

    rr_arbiter #(
        .N_CH   (N_CH)
    ) u_arb (
        .i_req   (bus.in_valid),
        .i_ptr   (r_ptr),
        .o_found (w_rr_found),
        .o_idx   (w_rr_idx)
    );

    // An out-of-range sel matches no channel and therefore never grants.
    always_comb begin
        w_fix_found = 1'b0;
        w_fix_idx   = bus.sel;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(bus.sel) == i) begin
                w_fix_found = bus.in_valid[i];
            end
        end
    end

    always_comb begin
        if (MODE == MODE_FIXED) begin
            w_cand_found = w_fix_found;
            w_cand_idx   = w_fix_idx;
        end else begin
            w_cand_found = w_rr_found;
            w_cand_idx   = w_rr_idx;
        end
    end

    always_comb begin
        w_grant_data  = '0;
        w_grant_valid = 1'b0;
        w_grant_last  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(r_grant) == i) begin
                w_grant_data  = bus.in_data[i*WIDTH +: WIDTH];
                w_grant_valid = bus.in_valid[i];
                w_grant_last  = bus.in_last[i];
            end
        end
    end

    // Next state and handshake; the output slot frees up when it is empty or draining.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = '0;
        w_slot_free = !r_out_valid || bus.out_ready;
        w_take      = 1'b0;
        w_take_last = 1'b0;
        case (r_state)
            ARB: begin
                if (w_cand_found) begin
                    w_state_nxt = LOCK;
                end
            end
            LOCK: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (int'(r_grant) == i) begin
                        w_in_ready[i] = w_slot_free;
                    end
                end
                w_take      = w_grant_valid && w_slot_free;
                w_take_last = w_take && w_grant_last;
                if (w_take_last) begin
                    w_state_nxt = ARB;
                end
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ptr starts at the top channel so that channel 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant     <= '0;
            r_ptr       <= SELW'(N_CH - 1);
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if ((r_state == ARB) && w_cand_found) begin
                r_grant <= w_cand_idx;
            end
            if (w_take_last && (MODE == MODE_RR)) begin
                r_ptr <= r_grant;
            end
            if (w_take) begin
                r_out_data  <= w_grant_data;
                r_out_last  <= w_grant_last;
                r_out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.grant_idx = r_grant;
    assign bus.busy      = (r_state == LOCK);

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_mux_rr
// Description : Scoreboard bench for stream_mux_rr (round-robin and fixed-select).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;
    import stream_mux_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_mux_rr_if #(.N_CH(4), .WIDTH(8)) rr_if ();
    stream_mux_rr_if #(.N_CH(5), .WIDTH(8)) fx_if ();

    stream_mux_rr #(.N_CH(4), .WIDTH(8), .MODE(MODE_RR)) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (rr_if.slave)
    );

    stream_mux_rr #(.N_CH(5), .WIDTH(8), .MODE(MODE_FIXED)) u_fx (
        .clk (clk),
        .rst (rst),
        .bus (fx_if.slave)
    );

    beat_t      src_rr[4][$];
    beat_t      src_fx[5][$];
    beat_t      exp_rr[$];
    beat_t      exp_fx[$];
    beat_t      mb_rr;
    beat_t      mb_fx;
    logic [3:0] pause_rr = '0;
    logic [3:0] hs_rr;
    logic [4:0] hs_fx;
    int         rr_cyc[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic send_rr(input int ch, input logic [7:0] d, input logic l);
        src_rr[ch].push_back('{d, l});
    endtask
    task automatic want_rr(input logic [7:0] d, input logic l);
        exp_rr.push_back('{d, l});
    endtask
    task automatic send_fx(input int ch, input logic [7:0] d, input logic l);
        src_fx[ch].push_back('{d, l});
    endtask
    task automatic want_fx(input logic [7:0] d, input logic l);
        exp_fx.push_back('{d, l});
    endtask

    // Producers: a beat leaves its source queue only on a real valid&ready handshake.
    initial begin
        rr_if.in_valid = '0;
        rr_if.in_data  = '0;
        rr_if.in_last  = '0;
        forever begin
            @(negedge clk);
            hs_rr = rr_if.in_valid & rr_if.in_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (hs_rr[i] && src_rr[i].size() > 0) void'(src_rr[i].pop_front());
                rr_if.in_valid[i] = (src_rr[i].size() > 0) && !pause_rr[i];
                if (src_rr[i].size() > 0) begin
                    rr_if.in_data[i*8 +: 8] = src_rr[i][0].d;
                    rr_if.in_last[i]        = src_rr[i][0].l;
                end
            end
        end
    end

    initial begin
        fx_if.in_valid = '0;
        fx_if.in_data  = '0;
        fx_if.in_last  = '0;
        forever begin
            @(negedge clk);
            hs_fx = fx_if.in_valid & fx_if.in_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 5; i++) begin
                if (hs_fx[i] && src_fx[i].size() > 0) void'(src_fx[i].pop_front());
                fx_if.in_valid[i] = (src_fx[i].size() > 0);
                if (src_fx[i].size() > 0) begin
                    fx_if.in_data[i*8 +: 8] = src_fx[i][0].d;
                    fx_if.in_last[i]        = src_fx[i][0].l;
                end
            end
        end
    end

    // Monitors: every delivered beat must be the next expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (rr_if.out_valid === 1'b1 && rr_if.out_ready === 1'b1) begin
                rr_cyc.push_back(cyc);
                if (exp_rr.size() == 0) begin
                    check("rr_extra_beat", 32'(rr_if.out_data), 32'hFFFF_FFFF);
                end else begin
                    mb_rr = exp_rr.pop_front();
                    check("rr_data", 32'(rr_if.out_data), 32'(mb_rr.d));
                    check("rr_last", 32'(rr_if.out_last), 32'(mb_rr.l));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (fx_if.out_valid === 1'b1 && fx_if.out_ready === 1'b1) begin
                if (exp_fx.size() == 0) begin
                    check("fx_extra_beat", 32'(fx_if.out_data), 32'hFFFF_FFFF);
                end else begin
                    mb_fx = exp_fx.pop_front();
                    check("fx_data", 32'(fx_if.out_data), 32'(mb_fx.d));
                    check("fx_last", 32'(fx_if.out_last), 32'(mb_fx.l));
                end
            end
        end
    end

    function automatic bit all_idle();
        bit idle = (exp_rr.size() == 0) && (exp_fx.size() == 0);
        for (int i = 0; i < 4; i++) if (src_rr[i].size() != 0) idle = 1'b0;
        for (int i = 0; i < 5; i++) if (src_fx[i].size() != 0) idle = 1'b0;
        return idle;
    endfunction

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(posedge clk);
            #1;
            done = all_idle();
        end
        check(name, 32'(done), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_rr_out(input logic [7:0] d, input string name);
        bit seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(posedge clk);
            #1;
            seen = rr_if.out_valid && (rr_if.out_data == d);
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_busy(input bit fixed, input string name);
        bit seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(posedge clk);
            #1;
            seen = fixed ? fx_if.busy : rr_if.busy;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic check_gaps(input string name, input int n, input int g0, input int g1, input int g2);
        int gaps[3];
        gaps = '{g0, g1, g2};
        check({name, "_count"}, 32'(rr_cyc.size()), 32'(n));
        for (int i = 0; i + 1 < rr_cyc.size() && i < 3; i++) begin
            check({name, "_gap"}, 32'(rr_cyc[i+1] - rr_cyc[i]), 32'(gaps[i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rr_if.out_ready = 1'b0;
        rr_if.sel       = '0;
        fx_if.out_ready = 1'b0;
        fx_if.sel       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rr_data",  32'(rr_if.out_data),  0);
        check("rst_rr_valid", 32'(rr_if.out_valid), 0);
        check("rst_rr_last",  32'(rr_if.out_last),  0);
        check("rst_rr_ready", 32'(rr_if.in_ready),  0);
        check("rst_rr_grant", 32'(rr_if.grant_idx), 0);
        check("rst_rr_busy",  32'(rr_if.busy),      0);
        check("rst_fx_valid", 32'(fx_if.out_valid), 0);
        check("rst_fx_ready", 32'(fx_if.in_ready),  0);
        check("rst_fx_busy",  32'(fx_if.busy),      0);
        rst = 1'b0;
        rr_if.out_ready = 1'b1;
        fx_if.out_ready = 1'b1;

        // All four channels hold single-beat packets: grants 0,1,2,3,0, one bubble each.
        rr_cyc.delete();
        send_rr(0, 8'h10, 1'b1); send_rr(1, 8'h11, 1'b1); send_rr(2, 8'h12, 1'b1);
        send_rr(3, 8'h13, 1'b1); send_rr(0, 8'h20, 1'b1);
        want_rr(8'h10, 1'b1); want_rr(8'h11, 1'b1); want_rr(8'h12, 1'b1);
        want_rr(8'h13, 1'b1); want_rr(8'h20, 1'b1);
        drain("t1_drain");
        check_gaps("t1", 5, 2, 2, 2);

        // Three-beat packet on channel 2 runs back-to-back; channel 1 waits for it.
        rr_cyc.delete();
        send_rr(2, 8'hA1, 1'b0); send_rr(2, 8'hA2, 1'b0); send_rr(2, 8'hA3, 1'b1);
        want_rr(8'hA1, 1'b0); want_rr(8'hA2, 1'b0); want_rr(8'hA3, 1'b1); want_rr(8'hB1, 1'b1);
        wait_busy(1'b0, "t2_busy");
        check("t2_grant", 32'(rr_if.grant_idx), 2);
        send_rr(1, 8'hB1, 1'b1);
        drain("t2_drain");
        check_gaps("t2", 4, 1, 1, 2);

        // Three cycles of backpressure while C2 sits in the output register.
        send_rr(3, 8'hC1, 1'b0); send_rr(3, 8'hC2, 1'b0);
        send_rr(3, 8'hC3, 1'b0); send_rr(3, 8'hC4, 1'b1);
        want_rr(8'hC1, 1'b0); want_rr(8'hC2, 1'b0); want_rr(8'hC3, 1'b0); want_rr(8'hC4, 1'b1);
        wait_rr_out(8'hC2, "t3_see_c2");
        rr_if.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t3_in_ready", 32'(rr_if.in_ready),  0);
            check("t3_hold",     32'(rr_if.out_data),  32'hC2);
            check("t3_valid",    32'(rr_if.out_valid), 1);
            @(posedge clk);
            #1;
        end
        rr_if.out_ready = 1'b1;
        drain("t3_drain");

        // Channel 0 packet moves ptr to 0, then reset lands mid-packet on channel 1.
        send_rr(0, 8'h30, 1'b1);
        want_rr(8'h30, 1'b1);
        drain("t5_pre_drain");
        send_rr(1, 8'h41, 1'b0); send_rr(1, 8'h42, 1'b0);
        send_rr(1, 8'h43, 1'b0); send_rr(1, 8'h44, 1'b1);
        wait_rr_out(8'h41, "t5_see_g1");
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 32'(rr_if.out_valid), 0);
        check("t5_rst_busy",  32'(rr_if.busy),      0);
        check("t5_rst_ready", 32'(rr_if.in_ready),  0);
        check("t5_rst_data",  32'(rr_if.out_data),  0);
        for (int i = 0; i < 4; i++) src_rr[i].delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_rr(2, 8'h52, 1'b1); send_rr(0, 8'h50, 1'b1);
        want_rr(8'h50, 1'b1); want_rr(8'h52, 1'b1);
        drain("t5_drain");

        // Locked channel 2 drops valid mid-packet; channel 1 must not sneak in.
        send_rr(2, 8'h61, 1'b0); send_rr(2, 8'h62, 1'b0); send_rr(2, 8'h63, 1'b1);
        want_rr(8'h61, 1'b0); want_rr(8'h62, 1'b0); want_rr(8'h63, 1'b1); want_rr(8'h71, 1'b1);
        wait_busy(1'b0, "t6_busy");
        send_rr(1, 8'h71, 1'b1);
        wait_rr_out(8'h61, "t6_see_l1");
        pause_rr[2] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t6_lock_busy",  32'(rr_if.busy),      1);
        check("t6_lock_grant", 32'(rr_if.grant_idx), 2);
        check("t6_idle_out",   32'(rr_if.out_valid), 0);
        check("t6_in_ready",   32'(rr_if.in_ready),  32'b0100);
        pause_rr[2] = 1'b0;
        drain("t6_drain");

        // Fixed select: sel moves 3 -> 0 mid-packet, then an out-of-range sel grants nothing.
        fx_if.sel = 3'd3;
        send_fx(3, 8'hD1, 1'b0); send_fx(3, 8'hD2, 1'b0); send_fx(3, 8'hD3, 1'b1);
        send_fx(0, 8'hE1, 1'b1);
        want_fx(8'hD1, 1'b0); want_fx(8'hD2, 1'b0); want_fx(8'hD3, 1'b1); want_fx(8'hE1, 1'b1);
        wait_busy(1'b1, "t4_busy");
        check("t4_grant", 32'(fx_if.grant_idx), 3);
        fx_if.sel = 3'd0;
        drain("t4_drain");
        fx_if.sel = 3'd5;
        send_fx(1, 8'hF1, 1'b1);
        want_fx(8'hF1, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("t4_sel5_busy", 32'(fx_if.busy), 0);
        end
        fx_if.sel = 3'd1;
        drain("t4_sel1_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
